// File: rtl/gpr_wb_scheduler.sv
// gpr_wb_scheduler
//   Write-back scheduler and scoreboard for the GPR file. Two producers, the
//   ALU (port 0) and the load unit (port 1), share the single register-file
//   write port under round-robin arbitration. A busy bit per register tracks
//   claimed-but-uncommitted destinations so decode can detect RAW hazards.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   issue_valid/issue_rd/issue_ready  destination claim from decode
//   chk_a, chk_b                   decode read selects checked for hazards
//   hazard                         a checked register is pending
//   fwd_a_hit, fwd_b_hit, fwd_data forwarding of the committing write
//   wb0_*  (valid, rd, data, ready) ALU write-back handshake
//   wb1_*  (valid, rd, data, ready) load write-back handshake
//   gpr_we, gpr_sel_d, gpr_data    registered register-file write port
//   busy                           scoreboard vector, one bit per register
//   pend_cnt                       registered population count of busy
//
// Build option
//   GPR_WB_BYPASS_EN  when defined, the write committing this cycle is
//                     forwarded to decode and exempted from hazard. When
//                     undefined the forward outputs are tied to zero.
//
// Handshake: a write-back transfer happens on a rising edge where
// wbN_valid and wbN_ready are both 1. ready is combinational from the
// valids and the round-robin pointer and is never high without valid; the
// producer keeps rd/data stable while valid is high and ready is low.

module gpr_wb_scheduler #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  input  logic [AW-1:0]     chk_a,
  input  logic [AW-1:0]     chk_b,
  output logic              hazard,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DW-1:0]     fwd_data,
  input  logic              wb0_valid,
  input  logic [AW-1:0]     wb0_rd,
  input  logic [DW-1:0]     wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [AW-1:0]     wb1_rd,
  input  logic [DW-1:0]     wb1_data,
  output logic              wb1_ready,
  output logic              gpr_we,
  output logic [AW-1:0]     gpr_sel_d,
  output logic [DW-1:0]     gpr_data,
  output logic [(1<<AW)-1:0] busy,
  output logic [AW:0]       pend_cnt
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] busy_q, busy_d;
  logic [AW:0]   pend_cnt_q, pend_cnt_d;
  logic          ptr_q, ptr_d;
  logic          gpr_we_q, gpr_we_d;
  logic [AW-1:0] gpr_sel_d_q, gpr_sel_d_d;
  logic [DW-1:0] gpr_data_q, gpr_data_d;

  logic          grant0, grant1;
  logic          issue_accept;
  logic [NR-1:0] set_mask, clr_mask;
  logic          commit_a, commit_b;

  // Arbitration: a lone requester always wins; under contention the
  // pointer picks the port and then flips so the other port goes next.
  always_comb begin
    grant0 = wb0_valid & (~wb1_valid | ~ptr_q);
    grant1 = wb1_valid & (~wb0_valid |  ptr_q);
    ptr_d  = ptr_q;
    if (wb0_valid && wb1_valid) begin
      ptr_d = ~ptr_q;
    end
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  always_comb begin
    gpr_we_d    = 1'b0;
    gpr_sel_d_d = gpr_sel_d_q;
    gpr_data_d  = gpr_data_q;
    if (grant0) begin
      gpr_we_d    = 1'b1;
      gpr_sel_d_d = wb0_rd;
      gpr_data_d  = wb0_data;
    end else if (grant1) begin
      gpr_we_d    = 1'b1;
      gpr_sel_d_d = wb1_rd;
      gpr_data_d  = wb1_data;
    end
  end

  // A register still committing is busy, so its claim is refused until the
  // cycle after the commit edge.
  assign issue_ready  = ~busy_q[issue_rd];
  assign issue_accept = issue_valid & issue_ready;

  // Clear comes from the write currently on the register-file port; the set
  // is applied after the clear so a same-index claim wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_accept) begin
      set_mask[issue_rd] = 1'b1;
    end
    if (gpr_we_q) begin
      clr_mask[gpr_sel_d_q] = 1'b1;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NR; i++) begin
      pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  assign commit_a = gpr_we_q & (chk_a == gpr_sel_d_q);
  assign commit_b = gpr_we_q & (chk_b == gpr_sel_d_q);

`ifdef GPR_WB_BYPASS_EN
  // The committing value is on fwd_data this cycle, so a read whose only
  // pending producer is that commit need not stall.
  assign fwd_a_hit = commit_a;
  assign fwd_b_hit = commit_b;
  assign fwd_data  = gpr_data_q;
  assign hazard    = (busy_q[chk_a] & ~commit_a) | (busy_q[chk_b] & ~commit_b);
`else
  assign fwd_a_hit = 1'b0;
  assign fwd_b_hit = 1'b0;
  assign fwd_data  = '0;
  assign hazard    = busy_q[chk_a] | busy_q[chk_b];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      pend_cnt_q  <= '0;
      ptr_q       <= 1'b0;
      gpr_we_q    <= 1'b0;
      gpr_sel_d_q <= '0;
      gpr_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      pend_cnt_q  <= pend_cnt_d;
      ptr_q       <= ptr_d;
      gpr_we_q    <= gpr_we_d;
      gpr_sel_d_q <= gpr_sel_d_d;
      gpr_data_q  <= gpr_data_d;
    end
  end

  assign busy      = busy_q;
  assign pend_cnt  = pend_cnt_q;
  assign gpr_we    = gpr_we_q;
  assign gpr_sel_d = gpr_sel_d_q;
  assign gpr_data  = gpr_data_q;

endmodule

// File: doc/gpr_wb_scheduler.md
# gpr_wb_scheduler

Write-back scheduler and scoreboard for the 8x8 general-purpose register file. It arbitrates two producers, the ALU (port 0) and the load unit (port 1), onto the register file's single write port with round-robin fairness. It tracks pending destination registers so that decode can detect RAW hazards on the two read selects. It sits between the execute/memory stages and the register file write inputs (`reg_write`, `sel_d`, `data_in`).

## Interface
- `DW`, 8, data width of register contents
- `AW`, 3, register index width; the register count is 2^AW
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `issue_valid`  in  1  decode requests to claim destination `issue_rd`
- `issue_rd`  in  AW  destination register being claimed
- `issue_ready`  out  1  claim is accepted this cycle; equals `~busy[issue_rd]`
- `chk_a`, `chk_b`  in  AW  decode read selects, checked for hazards
- `hazard`  out  1  combinational; a checked register is pending
- `fwd_a_hit`, `fwd_b_hit`  out  1  forward hit for read A / read B (active only with the macro)
- `fwd_data`  out  DW  forwarded value; equals `gpr_data`
- `wb0_valid`, `wb0_rd`, `wb0_data`, `wb0_ready`  in/in/in/out  1/AW/DW/1  ALU write-back handshake
- `wb1_valid`, `wb1_rd`, `wb1_data`, `wb1_ready`  in/in/in/out  1/AW/DW/1  load write-back handshake
- `gpr_we`, `gpr_sel_d`, `gpr_data`  out  1/AW/DW  registered; drive the register file `reg_write`, `sel_d` and `data_in`
- `busy`  out  2^AW  scoreboard bit vector
- `pend_cnt`  out  AW+1  number of set busy bits

## Operation
- **Arbitration, ready signals:** combinational. If only one `wbN_valid` is high, that port's `wbN_ready` is 1. If both are high, only the port selected by pointer `ptr` gets ready. A transfer occurs when valid and ready are both high.
- **Pointer `ptr`:** toggles to the other port only after a contended grant. Uncontended grants leave it unchanged.
- **Output registers:** on a transfer, `gpr_we` is set to 1 and `gpr_sel_d`/`gpr_data` are loaded from the winning port. With no transfer, `gpr_we` is 0 and the select/data registers hold their values.
- **Scoreboard set:** an accepted issue (`issue_valid & issue_ready`) sets `busy[issue_rd]`.
- **Scoreboard clear:** an edge with `gpr_we=1` clears `busy[gpr_sel_d]`.
- **Same-index set and clear on one edge:** the set wins.
- **Write to a non-busy register:** written normally; the scoreboard is unchanged.
- **`pend_cnt`:** a registered population count of `busy`, updated in the same edge as `busy`.
- **`hazard`:** `(busy[chk_a] | busy[chk_b])`, with the forward exemption below when the macro is defined.

## Timing
- **Reset values:** `busy`=0, `pend_cnt`=0, `ptr`=0 (port 0 favoured), `gpr_we`=0, `gpr_sel_d`=0, `gpr_data`=0.
- **Reset mid-operation:** the accepted write in flight is dropped and the scoreboard is cleared.
- **Transfer to write-port latency:** a transfer at edge N drives `gpr_we` during cycle N..N+1. The register file commits at edge N+1, and `busy` clears at that same edge.
- **Issue latency:** a claim accepted at edge N produces `busy`=1 and `hazard` visible from cycle N onward, i.e. immediately after the edge.
- **Throughput:** one write per cycle. Under continuous contention the ports strictly alternate; neither port waits more than 1 cycle.
- **Handshake rule:** the producer holds `rd`/`data` stable while `valid` is high and `ready` is low.
- **`issue_ready` during a commit:** stays 0 for a register being committed in the current cycle. The claim succeeds on the next cycle.

## Configuration
- **Macro:** `GPR_WB_BYPASS_EN`.
- **Defined:** while `gpr_we=1`, `fwd_a_hit`=1 if `chk_a==gpr_sel_d`, and likewise `fwd_b_hit` for `chk_b`. `fwd_data=gpr_data`. A checked register whose only pending write is the one committing this cycle does not raise `hazard`. Decode uses `fwd_data` in place of the register file bus.
- **Undefined:** `fwd_a_hit`, `fwd_b_hit` and `fwd_data` are tied to 0. `hazard` includes the committing register, costing one extra stall cycle per RAW dependency.

## Test plan
- **Reset check:** assert `reset` asynchronously mid-cycle with `wb0_valid`=1 and `busy`=0x0A. Outputs go to zero immediately, `pend_cnt`=0, and no `gpr_we` pulse follows.
- **Issue then write-back:** issue r3 (`busy`=0x08, `pend_cnt`=1, `hazard`=1 with `chk_a`=3). Then `wb0` rd=3 data=0x5A gives `gpr_we`=1, `gpr_sel_d`=3, `gpr_data`=0x5A one cycle later, and `busy`=0 after that edge.
- **Contention:** both ports valid for 4 cycles (rd 1/2, data 0x11/0x22). Grants go 0,1,0,1; `gpr_data` sequence is 0x11,0x22,0x11,0x22, and each ready deasserts on alternate cycles.
- **Set/clear collision:** while r5 commits (`gpr_we`=1, `gpr_sel_d`=5), a new issue of r6 is accepted and an issue of r5 gets `issue_ready`=0. The next cycle r5 issues successfully and `busy[5]`=1.
- **Bypass, macro on:** r2 pending, commit of r2 data 0x7E with `chk_b`=2 gives `hazard`=0, `fwd_b_hit`=1, `fwd_data`=0x7E.
- **Bypass, macro off:** same stimulus gives `hazard`=1 and the forward outputs are 0.
